// File: rtl/cvxif_result_queue_if.sv
// ============================================================================
// cvxif_result_queue_if : ALU result, commit and CPU result channels
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cvxif_result_queue_if #(
  parameter int Depth       = 4,
  parameter int XLEN        = 32,
  parameter int IdWidth     = 4,
  parameter int HartIdWidth = 1
);
  localparam int CntW = $clog2(Depth) + 1;

  logic                   alu_valid_i;
  logic                   alu_ready_o;
  logic [HartIdWidth-1:0] alu_hartid_i;
  logic [IdWidth-1:0]     alu_id_i;
  logic [XLEN-1:0]        alu_data_i;
  logic [4:0]             alu_rd_i;
  logic                   alu_we_i;

  logic                   commit_valid_i;
  logic [IdWidth-1:0]     commit_id_i;
  logic                   commit_kill_i;

  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [HartIdWidth-1:0] result_hartid_o;
  logic [IdWidth-1:0]     result_id_o;
  logic [XLEN-1:0]        result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;
  logic [CntW-1:0]        count_o;

  modport slave (
    input  alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output alu_ready_o,
    output result_valid_o, result_hartid_o, result_id_o, result_data_o,
    output result_rd_o, result_we_o, count_o
  );

  modport master (
    output alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i, alu_rd_i, alu_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  alu_ready_o,
    input  result_valid_o, result_hartid_o, result_id_o, result_data_o,
    input  result_rd_o, result_we_o, count_o
  );
endinterface

`default_nettype wire

// File: rtl/cvxif_result_queue.sv
// ============================================================================
// cvxif_result_queue : circular result FIFO with commit-kill and auto-drop
// Revision: 1.0
// ============================================================================
`default_nettype none

module cvxif_result_queue #(
  parameter int Depth       = 4,
  parameter int XLEN        = 32,
  parameter int IdWidth     = 4,
  parameter int HartIdWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cvxif_result_queue_if.slave  bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [HartIdWidth-1:0] hartid_q [Depth];
  logic [IdWidth-1:0]     id_q     [Depth];
  logic [XLEN-1:0]        data_q   [Depth];
  logic [4:0]             rd_q     [Depth];
  logic                   we_q     [Depth];

  logic [Depth-1:0] killed_q, killed_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic not_empty, head_killed, valid, drop, ready, push, pop, kill_en;

  always_comb begin
    not_empty   = (count_q != '0);
    head_killed = killed_q[rptr_q];
    valid       = not_empty && !head_killed;
    drop        = not_empty && head_killed;
    ready       = (count_q < CntW'(Depth));
    push        = bus.alu_valid_i && ready;
    pop         = valid && bus.result_ready_i;
    kill_en     = bus.commit_valid_i && bus.commit_kill_i;
  end

  // Occupancy of slot i is judged by its distance from the read pointer;
  // the presented head is shielded so a valid output stays stable.
  always_comb begin
    killed_d = killed_q;
    for (int i = 0; i < Depth; i++) begin
      if (kill_en
          && ({1'b0, PtrW'(PtrW'(i) - rptr_q)} < count_q)
          && (id_q[i] == bus.commit_id_i)
          && !((PtrW'(i) == rptr_q) && valid)) begin
        killed_d[i] = 1'b1;
      end
    end
    if (push) begin
      killed_d[wptr_q] = kill_en && (bus.alu_id_i == bus.commit_id_i);
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = (pop || drop) ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    case ({push, (pop || drop)})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      killed_q <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
    end else begin
      killed_q <= killed_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      hartid_q[wptr_q] <= bus.alu_hartid_i;
      id_q[wptr_q]     <= bus.alu_id_i;
      data_q[wptr_q]   <= bus.alu_data_i;
      rd_q[wptr_q]     <= bus.alu_rd_i;
      we_q[wptr_q]     <= bus.alu_we_i;
    end
  end

  assign bus.alu_ready_o     = ready;
  assign bus.result_valid_o  = valid;
  assign bus.result_hartid_o = hartid_q[rptr_q];
  assign bus.result_id_o     = id_q[rptr_q];
  assign bus.result_data_o   = data_q[rptr_q];
  assign bus.result_rd_o     = rd_q[rptr_q];
  assign bus.result_we_o     = we_q[rptr_q];
  assign bus.count_o         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_cvxif_result_queue.sv
// ============================================================================
// tb_cvxif_result_queue : directed stimulus with scoreboard-based checking
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cvxif_result_queue;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  cvxif_result_queue_if #(.Depth(4), .XLEN(32), .IdWidth(4), .HartIdWidth(1)) bus ();

  cvxif_result_queue #(.Depth(4), .XLEN(32), .IdWidth(4), .HartIdWidth(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct packed {
    logic        hartid;
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic hart, input logic [3:0] id, input logic [31:0] data,
                      input logic [4:0] rd, input logic we, input bit expect_out);
    res_t e;
    bus.alu_valid_i  = 1'b1;
    bus.alu_hartid_i = hart;
    bus.alu_id_i     = id;
    bus.alu_data_i   = data;
    bus.alu_rd_i     = rd;
    bus.alu_we_i     = we;
    e = '{hartid: hart, id: id, data: data, rd: rd, we: we};
    if (expect_out) exp_q.push_back(e);
    tick();
    bus.alu_valid_i = 1'b0;
  endtask

  task automatic kill(input logic [3:0] id, input logic k);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = k;
    tick();
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
  endtask

  // Monitor: compares each accepted result and checks hold-stability of a stalled head
  res_t prev;
  bit   prev_hold = 1'b0;
  always @(negedge clk_i) begin
    res_t act;
    res_t e;
    act = '{hartid: bus.result_hartid_o, id: bus.result_id_o, data: bus.result_data_o,
            rd: bus.result_rd_o, we: bus.result_we_o};
    if (rst_ni && bus.result_valid_o) begin
      if (prev_hold) check("stable_payload", 64'(act), 64'(prev));
      if (bus.result_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_id", 64'(act.id), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("result_payload", 64'(act), 64'(e));
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev      = act;
      end
    end else begin
      if (rst_ni && prev_hold) check("valid_dropped_before_pop", 64'(bus.result_valid_o), 64'd1);
      prev_hold = 1'b0;
    end
  end

  initial begin
    bus.alu_valid_i    = 1'b0;
    bus.alu_hartid_i   = 1'b0;
    bus.alu_id_i       = '0;
    bus.alu_data_i     = '0;
    bus.alu_rd_i       = '0;
    bus.alu_we_i       = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.result_ready_i = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst_ready", 64'(bus.alu_ready_o), 64'd1);
    check("rst_count", 64'(bus.count_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_count", 64'(bus.count_o), 64'd0);

    // Single result, one cycle latency
    bus.result_ready_i = 1'b1;
    push(1'b1, 4'd3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1);
    check("single_valid_n1", 64'(bus.result_valid_o), 64'd1);
    check("single_count_n1", 64'(bus.count_o), 64'd1);
    tick();
    check("single_count_n2", 64'(bus.count_o), 64'd0);

    // Fill and backpressure
    bus.result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 4'(i), 32'h1000 + 32'(i), 5'(i + 1), i[0], 1'b1);
    check("fill_count", 64'(bus.count_o), 64'd4);
    check("fill_ready", 64'(bus.alu_ready_o), 64'd0);
    push(1'b0, 4'd9, 32'hBAD0BAD0, 5'd9, 1'b1, 1'b0);
    check("full_push_ignored", 64'(bus.count_o), 64'd4);
    bus.result_ready_i = 1'b1;
    repeat (4) tick();
    check("drain_count", 64'(bus.count_o), 64'd0);

    // Kill a queued (non-head) entry; non-kill commit has no effect
    bus.result_ready_i = 1'b0;
    push(1'b0, 4'd1, 32'hA1, 5'd1, 1'b1, 1'b1);
    push(1'b0, 4'd2, 32'hA2, 5'd2, 1'b1, 1'b0);
    push(1'b0, 4'd3, 32'hA3, 5'd3, 1'b1, 1'b1);
    check("kq_head_valid", 64'(bus.result_valid_o), 64'd1);
    check("kq_head_id", 64'(bus.result_id_o), 64'd1);
    kill(4'd2, 1'b1);
    kill(4'd3, 1'b0);
    check("kq_count", 64'(bus.count_o), 64'd3);
    bus.result_ready_i = 1'b1;
    tick();
    check("kq_dropped_not_valid", 64'(bus.result_valid_o), 64'd0);
    repeat (2) tick();
    check("kq_drain_count", 64'(bus.count_o), 64'd0);

    // Kill aimed at the presented head is ignored
    bus.result_ready_i = 1'b0;
    push(1'b1, 4'd1, 32'h12345678, 5'd7, 1'b0, 1'b1);
    kill(4'd1, 1'b1);
    check("khead_valid", 64'(bus.result_valid_o), 64'd1);
    check("khead_data", 64'(bus.result_data_o), 64'h12345678);
    bus.result_ready_i = 1'b1;
    tick();
    check("khead_count", 64'(bus.count_o), 64'd0);

    // Kill matching the push cycle: entry enters killed and is dropped
    bus.commit_valid_i = 1'b1;
    bus.commit_kill_i  = 1'b1;
    bus.commit_id_i    = 4'd5;
    push(1'b0, 4'd5, 32'h55, 5'd5, 1'b1, 1'b0);
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
    check("kpush_count", 64'(bus.count_o), 64'd1);
    check("kpush_valid", 64'(bus.result_valid_o), 64'd0);
    tick();
    check("kpush_dropped", 64'(bus.count_o), 64'd0);

    // Simultaneous push and pop at count 2
    bus.result_ready_i = 1'b0;
    push(1'b0, 4'd10, 32'hC0, 5'd10, 1'b1, 1'b1);
    push(1'b1, 4'd11, 32'hC1, 5'd11, 1'b0, 1'b1);
    check("pp_count_before", 64'(bus.count_o), 64'd2);
    bus.result_ready_i = 1'b1;
    push(1'b0, 4'd12, 32'hC2, 5'd12, 1'b1, 1'b1);
    check("pp_count_after", 64'(bus.count_o), 64'd2);
    repeat (2) tick();
    check("pp_drain_count", 64'(bus.count_o), 64'd0);

    // Wrap-around: 10 back-to-back results
    for (int i = 0; i < 10; i++)
      push(i[1], 4'(i + 4), 32'hF000_0000 + 32'(i * 3), 5'(i + 20), i[0], 1'b1);
    tick();
    check("wrap_count", 64'(bus.count_o), 64'd0);

    // Reset mid-operation loses queued entries
    bus.result_ready_i = 1'b0;
    push(1'b0, 4'd7, 32'h77, 5'd7, 1'b1, 1'b0);
    push(1'b0, 4'd8, 32'h88, 5'd8, 1'b1, 1'b0);
    push(1'b0, 4'd9, 32'h99, 5'd9, 1'b1, 1'b0);
    check("mid_count", 64'(bus.count_o), 64'd3);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("mid_rst_count", 64'(bus.count_o), 64'd0);
    check("mid_rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("mid_rst_ready", 64'(bus.alu_ready_o), 64'd1);
    bus.result_ready_i = 1'b1;
    push(1'b1, 4'd14, 32'hCAFEF00D, 5'd31, 1'b1, 1'b1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
